// File: rtl/uart_seq_pkg.sv
// Shared types and defaults for the UART command-sequence engine.
package uart_seq_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    // Slowest bring-up link: one 11-bit frame plus margin, rounded to 2,000,000 cycles.
    localparam int CLK_FRE         = 50_000_000;
    localparam int BAUD_RATE       = 300;
    localparam int FRAME_CYC       = (CLK_FRE / BAUD_RATE) * 11;
    localparam int TIMEOUT_MARGIN  = 166_674;
    localparam int TIMEOUT_CYC_DEF = FRAME_CYC + TIMEOUT_MARGIN;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACC  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } seq_state_t;

endpackage

// File: rtl/uart_seq_table.sv
// Command byte table: synchronous write, asynchronous read, cleared on reset.
module uart_seq_table
    import uart_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SEQ_DEPTH  = 16,
    parameter int ADDR_W     = $clog2(SEQ_DEPTH)
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [SEQ_DEPTH];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SEQ_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Replays a host-loaded byte table into a valid/ready UART transmitter,
// with optional looping, inter-byte gap, abort and per-byte timeout.
module uart_cmd_sequencer
    import uart_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SEQ_DEPTH   = 16,
    parameter int ADDR_W      = $clog2(SEQ_DEPTH),
    parameter int GAP_CYCLES  = 0,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  i_cfg_we,
    input  logic [ADDR_W-1:0]     i_cfg_addr,
    input  logic [DATA_WIDTH-1:0] i_cfg_data,
    input  logic [ADDR_W:0]       i_seq_len,
    input  logic                  i_loop,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_tx_ready,
    output logic [DATA_WIDTH-1:0] o_data_tx,
    output logic                  o_data_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err_timeout,
    output logic [ADDR_W-1:0]     o_byte_idx
);

    localparam int TW         = $clog2(TIMEOUT_CYC + 1);
    localparam int GW         = $clog2(GAP_CYCLES + 2);
    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [ADDR_W:0] DEPTH_L  = SEQ_DEPTH[ADDR_W:0];
    localparam logic [TW-1:0]   TOUT_L   = TIMEOUT_CYC[TW-1:0];
    localparam logic [GW-1:0]   GAP_LAST = GAP_LAST_I[GW-1:0];

    seq_state_t state_q, state_d;

    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [ADDR_W:0]       len_q, len_d;
    logic                  loop_q, loop_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [TW-1:0]         tout_q, tout_d;
    logic                  ready_prev_q;
    logic [DATA_WIDTH-1:0] data_tx_q, data_tx_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [ADDR_W-1:0]     byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ready_rise;
    logic                  advance;

    uart_seq_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEQ_DEPTH  (SEQ_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_table (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .we      (i_cfg_we && (state_q == ST_IDLE)),
        .waddr   (i_cfg_addr),
        .wdata   (i_cfg_data),
        .raddr   (idx_q),
        .rdata   (rd_data)
    );

    assign ready_rise = i_tx_ready && !ready_prev_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort is applied last so it overrides any advance, done or timeout in the same cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        loop_d     = loop_q;
        gap_d      = gap_q;
        tout_d     = tout_q;
        data_tx_d  = data_tx_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        byte_idx_d = byte_idx_q;
        advance    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_seq_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d   = (i_seq_len > DEPTH_L) ? DEPTH_L : i_seq_len;
                        loop_d  = i_loop;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (i_tx_ready) begin
                    data_tx_d  = rd_data;
                    valid_d    = 1'b1;
                    byte_idx_d = idx_q;
                    tout_d     = '0;
                    state_d    = ST_WAIT_ACC;
                end
            end
            ST_WAIT_ACC, ST_WAIT_DONE: begin
                tout_d = tout_q + 1'b1;
                if (state_q == ST_WAIT_ACC && !i_tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (state_q == ST_WAIT_DONE && ready_rise) begin
                    if (GAP_CYCLES > 0) begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (tout_d == TOUT_L) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    advance = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if ({1'b0, idx_q} != len_q - 1'b1) begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_ISSUE;
            end else if (loop_q) begin
                idx_d   = '0;
                state_d = ST_ISSUE;
            end else begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        end

        if (i_abort && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            valid_d    = 1'b0;
            done_d     = 1'b0;
            err_d      = err_q;
            data_tx_d  = data_tx_q;
            byte_idx_d = byte_idx_q;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            len_q        <= '0;
            loop_q       <= 1'b0;
            gap_q        <= '0;
            tout_q       <= '0;
            ready_prev_q <= 1'b1;
            data_tx_q    <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            byte_idx_q   <= '0;
        end else begin
            idx_q        <= idx_d;
            len_q        <= len_d;
            loop_q       <= loop_d;
            gap_q        <= gap_d;
            tout_q       <= tout_d;
            ready_prev_q <= i_tx_ready;
            data_tx_q    <= data_tx_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            byte_idx_q   <= byte_idx_d;
        end
    end

    assign o_data_tx     = data_tx_q;
    assign o_data_valid  = valid_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_err_timeout = err_q;
    assign o_byte_idx    = byte_idx_q;

endmodule
